// File: rtl/udp_loop_pkt_buf_if.sv
// RX/TX handshake bundle between the UDP engines and the loopback packet buffer.
// master = UDP RX/TX engines, slave = buffer.
interface udp_loop_pkt_buf_if #(
  parameter int DATA_W = 32
);
  logic              rx_en;
  logic [DATA_W-1:0] rx_data;
  logic              rx_pkg_done;
  logic [15:0]       rx_byte_num;
  logic              tx_start_en;
  logic [15:0]       tx_byte_num;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              tx_pkg_done;

  modport master (
    output rx_en, rx_data, rx_pkg_done, rx_byte_num, tx_req, tx_pkg_done,
    input  tx_start_en, tx_byte_num, tx_data
  );

  modport slave (
    input  rx_en, rx_data, rx_pkg_done, rx_byte_num, tx_req, tx_pkg_done,
    output tx_start_en, tx_byte_num, tx_data
  );
endinterface

// File: rtl/udp_loop_pkt_buf.sv
// Loopback packet buffer: circular data RAM plus descriptor queue between UDP RX and TX.
// Whole packets are committed and replayed in order, or dropped without touching queued data.
module udp_loop_pkt_buf #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int MAX_PKTS   = 8,
  parameter int IFG_CYCLES = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      loop_en,
  udp_loop_pkt_buf_if.slave         bus,
  output logic [$clog2(MAX_PKTS):0] pkt_cnt,
  output logic [15:0]               drop_cnt,
  output logic                      busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int QW = $clog2(MAX_PKTS);
  localparam int CW = QW + 1;
  localparam int GW = $clog2(IFG_CYCLES + 1);

  typedef struct packed {
    logic [15:0]   byte_num;
    logic [PW-1:0] wcnt;
  } desc_t;

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  logic [DATA_W-1:0] mem    [DEPTH];
  desc_t             desc_q [MAX_PKTS];

  logic [PW-1:0]     wr_ptr, wr_base, wcnt, rd_ptr, budget;
  logic              ovf;
  logic [QW-1:0]     q_wr, q_rd;
  state_t            state, state_nx;
  logic [GW-1:0]     gap_cnt;
  logic [15:0]       byte_num_q;
  logic [DATA_W-1:0] data_q;
  logic              start_en, ld, pop;

  logic [PW-1:0]     free, wr_ptr_w, wcnt_w;
  logic              wr_ok, ovf_w, q_full, do_drop, do_disc, do_commit, rd_ok;
  desc_t             head;

  // A word arriving with rx_pkg_done is folded in before the end-of-packet decision.
  assign free      = PW'(DEPTH) - (wr_ptr - rd_ptr);
  assign wr_ok     = bus.rx_en && (free != '0) && !ovf;
  assign wr_ptr_w  = wr_ptr + PW'(wr_ok);
  assign wcnt_w    = wcnt + PW'(wr_ok);
  assign ovf_w     = ovf || (bus.rx_en && !wr_ok);
  assign q_full    = (pkt_cnt == CW'(MAX_PKTS));
  assign do_drop   = bus.rx_pkg_done && (ovf_w || q_full);
  assign do_disc   = bus.rx_pkg_done && !do_drop && !loop_en;
  assign do_commit = bus.rx_pkg_done && !do_drop && loop_en && (wcnt_w != '0);
  assign head      = desc_q[q_rd];
  assign rd_ok     = (state == SEND) && bus.tx_req && (budget != '0);

  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= bus.rx_data;

  always_ff @(posedge clk)
    if (do_commit) desc_q[q_wr] <= '{byte_num: bus.rx_byte_num, wcnt: wcnt_w};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      wr_base  <= '0;
      wcnt     <= '0;
      ovf      <= 1'b0;
      q_wr     <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr_w;
      wcnt   <= wcnt_w;
      ovf    <= ovf_w;
      if (bus.rx_pkg_done) begin
        wcnt <= '0;
        ovf  <= 1'b0;
        if (do_drop) begin
          wr_ptr <= wr_base;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else if (do_disc) begin
          wr_ptr <= wr_base;
        end else if (do_commit) begin
          wr_base <= wr_ptr_w;
          q_wr    <= q_wr + QW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pkt_cnt <= '0;
    else if (do_commit && !pop) pkt_cnt <= pkt_cnt + CW'(1);
    else if (pop && !do_commit) pkt_cnt <= pkt_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_en = 1'b0;
    ld       = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE:  if (pkt_cnt != '0) begin
               ld       = 1'b1;
               state_nx = START;
             end
      START: begin
               start_en = 1'b1;
               state_nx = SEND;
             end
      SEND:  if (bus.tx_pkg_done) begin
               pop      = 1'b1;
               state_nx = GAP;
             end
      GAP:   if (gap_cnt == GW'(IFG_CYCLES - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Header is loaded on the IDLE->START edge so tx_byte_num is valid with tx_start_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      q_rd       <= '0;
      budget     <= '0;
      byte_num_q <= '0;
      data_q     <= '0;
      gap_cnt    <= '0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      if (ld) begin
        byte_num_q <= head.byte_num;
        budget     <= head.wcnt;
      end
      if (rd_ok) begin
        data_q <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + PW'(1);
        budget <= budget - PW'(1);
      end
      // Skipping the whole remaining budget also covers a read in this same cycle.
      if (pop) begin
        rd_ptr <= rd_ptr + budget;
        budget <= '0;
        q_rd   <= q_rd + QW'(1);
      end
    end
  end

  assign bus.tx_start_en = start_en;
  assign bus.tx_byte_num = byte_num_q;
  assign bus.tx_data     = data_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_udp_loop_pkt_buf.sv
// Directed scoreboard bench for udp_loop_pkt_buf with a small RAM and descriptor queue.
module tb_udp_loop_pkt_buf;
  localparam int DATA_W = 32, DEPTH = 16, MAX_PKTS = 4, IFG = 4;

  logic        clk = 1'b0, rst_n = 1'b0, loop_en = 1'b1;
  logic [2:0]  pkt_cnt;
  logic [15:0] drop_cnt;
  logic        busy;
  int          cyc = 0, n_chk = 0, n_fail = 0, last_done = -1000;

  udp_loop_pkt_buf_if #(.DATA_W(DATA_W)) bus ();

  udp_loop_pkt_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_PKTS(MAX_PKTS), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst_n(rst_n), .loop_en(loop_en), .bus(bus),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] bn; int nw; logic [31:0] base; } pkt_t;
  typedef struct { logic [15:0] bn; int c; } start_t;
  pkt_t   exp_q[$];
  start_t st_q[$];
  pkt_t   cur;

  always @(negedge clk)
    if (bus.tx_start_en === 1'b1) st_q.push_back('{bn: bus.tx_byte_num, c: cyc});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic rx_cyc(input logic en, input logic [31:0] d, input logic done, input logic [15:0] bn);
    @(negedge clk);
    bus.rx_en = en; bus.rx_data = d; bus.rx_pkg_done = done; bus.rx_byte_num = bn;
  endtask

  task automatic rx_pkt(input int nw, input logic [31:0] base, input logic [15:0] bn,
                        input bit commit, output int done_cyc);
    for (int i = 0; i < nw; i++) rx_cyc(1'b1, base + 32'(i), 1'b0, 16'd0);
    rx_cyc(1'b0, 32'd0, 1'b1, bn);
    done_cyc = cyc;
    rx_cyc(1'b0, 32'd0, 1'b0, 16'd0);
    if (commit) exp_q.push_back('{bn: bn, nw: nw, base: base});
  endtask

  task automatic wait_start(output int sc);
    int     n = 0;
    start_t s;
    sc = -1;
    cur.nw = 0;
    while (st_q.size() == 0 && n < 200) begin @(posedge clk); n++; end
    check("tx_start_seen", 32'(st_q.size() != 0), 32'd1);
    if (st_q.size() != 0) begin
      s  = st_q.pop_front();
      sc = s.c;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check("tx_byte_num", 32'(s.bn), 32'(cur.bn));
        check("ifg_spacing", 32'((s.c - last_done) >= IFG + 2), 32'd1);
      end
    end
  endtask

  task automatic tx_read(input int nw, input logic [31:0] base);
    for (int i = 0; i < nw; i++) begin
      @(negedge clk); bus.tx_req = 1'b1;
      @(negedge clk); bus.tx_req = 1'b0;
      check("tx_data", bus.tx_data, base + 32'(i));
    end
  endtask

  task automatic tx_done();
    @(negedge clk); bus.tx_pkg_done = 1'b1; last_done = cyc;
    @(negedge clk); bus.tx_pkg_done = 1'b0;
  endtask

  task automatic consume();
    int sc;
    wait_start(sc);
    tx_read(cur.nw, cur.base);
    tx_done();
  endtask

  initial begin
    int nc, sc;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc, sc;
    bus.rx_en = 1'b0; bus.rx_data = '0; bus.rx_pkg_done = 1'b0; bus.rx_byte_num = '0;
    bus.tx_req = 1'b0; bus.tx_pkg_done = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tx_start_en", 32'(bus.tx_start_en), 32'd0);
    check("rst_tx_byte_num", 32'(bus.tx_byte_num), 32'd0);
    check("rst_tx_data", bus.tx_data, 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // single packet, exact commit->start latency, budget-exhausted tx_req holds data
    rx_pkt(5, 32'h1, 16'd20, 1'b1, nc);
    check("start_not_early", 32'(bus.tx_start_en), 32'd0);
    check("pkt_cnt_commit", 32'(pkt_cnt), 32'd1);
    wait_start(sc);
    check("commit_to_start", 32'(sc - nc), 32'd2);
    tx_read(cur.nw, cur.base);
    @(negedge clk); bus.tx_req = 1'b1;
    @(negedge clk); bus.tx_req = 1'b0;
    check("tx_data_hold", bus.tx_data, 32'h5);
    tx_done();
    check("pkt_cnt_pop", 32'(pkt_cnt), 32'd0);
    check("busy_gap", 32'(busy), 32'd1);

    // three queued packets replayed in order
    rx_pkt(4, 32'h100, 16'd16, 1'b1, nc);
    rx_pkt(7, 32'h200, 16'd28, 1'b1, nc);
    rx_pkt(1, 32'h300, 16'd4, 1'b1, nc);
    check("pkt_cnt_q3", 32'(pkt_cnt), 32'd3);
    repeat (3) consume();
    check("pkt_cnt_q0", 32'(pkt_cnt), 32'd0);

    // RAM overflow: second 10-word packet dropped, a 6-word one still fits
    rx_pkt(10, 32'h400, 16'd40, 1'b1, nc);
    rx_pkt(10, 32'h500, 16'd40, 1'b0, nc);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
    check("ovf_pkt_cnt", 32'(pkt_cnt), 32'd1);
    rx_pkt(6, 32'h600, 16'd24, 1'b1, nc);
    check("ovf_pkt_cnt2", 32'(pkt_cnt), 32'd2);
    repeat (2) consume();

    // descriptor queue full while TX is stalled
    for (int i = 0; i < MAX_PKTS + 1; i++)
      rx_pkt(1, 32'h700 + 32'(i), 16'd4, (i < MAX_PKTS), nc);
    check("full_drop_cnt", 32'(drop_cnt), 32'd2);
    check("full_pkt_cnt", 32'(pkt_cnt), 32'(MAX_PKTS));
    repeat (MAX_PKTS) consume();

    // last word with rx_pkg_done, commit in the same cycle as the pop
    rx_pkt(2, 32'h800, 16'd8, 1'b1, nc);
    wait_start(sc);
    rx_cyc(1'b1, 32'h900, 1'b0, 16'd0);
    rx_cyc(1'b1, 32'h901, 1'b0, 16'd0);
    rx_cyc(1'b0, 32'd0, 1'b0, 16'd0);
    tx_read(cur.nw, cur.base);
    @(negedge clk);
    bus.tx_pkg_done = 1'b1; last_done = cyc;
    bus.rx_en = 1'b1; bus.rx_data = 32'h902; bus.rx_pkg_done = 1'b1; bus.rx_byte_num = 16'd12;
    exp_q.push_back('{bn: 16'd12, nw: 3, base: 32'h900});
    @(negedge clk);
    bus.tx_pkg_done = 1'b0; bus.rx_en = 1'b0; bus.rx_pkg_done = 1'b0;
    check("commit_pop_pkt_cnt", 32'(pkt_cnt), 32'd1);
    consume();

    // loop_en=0 discards without counting a drop
    loop_en = 1'b0;
    rx_cyc(1'b1, 32'hA00, 1'b0, 16'd0);
    rx_cyc(1'b1, 32'hA01, 1'b1, 16'd8);
    rx_cyc(1'b0, 32'd0, 1'b0, 16'd0);
    check("disc_drop_cnt", 32'(drop_cnt), 32'd2);
    check("disc_pkt_cnt", 32'(pkt_cnt), 32'd0);
    repeat (20) @(negedge clk);
    check("disc_no_start", 32'(st_q.size()), 32'd0);
    loop_en = 1'b1;

    // reset during SEND
    rx_pkt(3, 32'hB00, 16'd12, 1'b1, nc);
    wait_start(sc);
    tx_read(1, cur.base);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("srst_tx_start_en", 32'(bus.tx_start_en), 32'd0);
    check("srst_tx_byte_num", 32'(bus.tx_byte_num), 32'd0);
    check("srst_tx_data", bus.tx_data, 32'd0);
    check("srst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("srst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("srst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    st_q.delete();
    repeat (30) @(negedge clk);
    check("srst_no_replay", 32'(st_q.size()), 32'd0);
    rx_pkt(2, 32'hC00, 16'd8, 1'b1, nc);
    consume();
    check("final_pkt_cnt", 32'(pkt_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_loop_pkt_buf.md
# udp_loop_pkt_buf

Single-clock packet buffer that sits between the UDP receive and transmit paths of the loopback design and replaces the plain word FIFO used there today. It stores up to MAX_PKTS complete received packets in a circular data RAM with a per-packet descriptor queue. It replays them in order with the correct per-packet byte count, and it discards packets that do not fit without corrupting queued ones. Used where the RX and TX UDP logic share one clock.

## Interface
- DATA_W, 32: width of rx_data/tx_data; multiple of 8.
- DEPTH, 1024: data RAM depth in words; power of 2, ≥ 4.
- MAX_PKTS, 8: descriptor queue depth; power of 2.
- IFG_CYCLES, 12: idle cycles after tx_pkg_done before the next tx_start_en; ≥ 1.

- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- loop_en  in  1  1 = replay packets; 0 = discard completed packets on commit.
- rx_en  in  1  write strobe for rx_data.
- rx_data  in  DATA_W  received word.
- rx_pkg_done  in  1  one-cycle pulse, end of received packet.
- rx_byte_num  in  16  byte count of packet; sampled with rx_pkg_done.
- tx_start_en  out  1  one-cycle pulse, starts a UDP transmission.
- tx_byte_num  out  16  byte count of current TX packet; stable from tx_start_en until tx_pkg_done.
- tx_req  in  1  read strobe from the UDP TX engine.
- tx_data  out  DATA_W  word read; valid the cycle after tx_req.
- tx_pkg_done  in  1  one-cycle pulse, TX engine finished the packet.
- pkt_cnt  out  log2(MAX_PKTS)+1  committed packets not yet fully sent.
- drop_cnt  out  16  dropped packets, saturates at 16'hFFFF.
- busy  out  1  TX FSM not in IDLE.

## Operation
- Pointers are log2(DEPTH)+1 bits (extra wrap bit). free = DEPTH − (wr_ptr − rd_ptr), computed modulo 2^(log2(DEPTH)+1).
- Write side: wr_base holds the start of the open packet. On rx_en, if free > 0 and no overflow flag is set: write RAM[wr_ptr] and increment wr_ptr and wcnt. Otherwise set ovf and ignore the word.
- On rx_pkg_done, one of four outcomes applies:
  - Drop: ovf=1, or the descriptor queue is full. Set wr_ptr ← wr_base and increment drop_cnt.
  - Discard: loop_en=0. Set wr_ptr ← wr_base; drop_cnt is not incremented.
  - Empty: wcnt=0 (including rx_pkg_done with no words). Ignored; not counted.
  - Commit: push descriptor {rx_byte_num, wcnt} and set wr_base ← wr_ptr.
  - In all four cases, clear wcnt and ovf.
- rx_en and rx_pkg_done in the same cycle: the word belongs to the ending packet and is written before the commit/drop decision.
- TX FSM states:
  - IDLE: go to START when the descriptor queue is non-empty.
  - START: load tx_byte_num and the word budget from the queue head. Pulse tx_start_en for exactly 1 cycle. Go to SEND.
  - SEND: each tx_req with budget > 0 reads RAM[rd_ptr] into tx_data next cycle, increments rd_ptr, and decrements the budget. tx_req with budget = 0 is ignored and tx_data holds. tx_pkg_done moves to GAP.
  - GAP: pop the descriptor on entry. If budget > 0, set rd_ptr ← rd_ptr + budget so unread words are freed. Count IFG_CYCLES, then go to IDLE.
- pkt_cnt increments on commit, decrements on pop. Commit and pop in the same cycle leave it unchanged.
- loop_en going low does not abort the packet in flight; already-queued packets are still sent.

## Timing
- Reset values: tx_start_en=0, tx_byte_num=0, tx_data=0, pkt_cnt=0, drop_cnt=0, busy=0. All pointers, counters and the descriptor queue are cleared and the FSM goes to IDLE.
- Reset mid-packet or mid-transmission loses all buffered data. No tx_start_en is issued until a new commit.
- Commit-to-tx_start_en latency with FSM in IDLE: commit at cycle N, IDLE sees non-empty at N+1, START at N+2. tx_start_en is high in cycle N+2.
- tx_req→tx_data: 1 cycle (registered RAM read).
- Back-to-back packets: the next tx_start_en comes no earlier than IFG_CYCLES+2 cycles after tx_pkg_done.
- RAM space freed by reads in cycle N is usable by writes in cycle N+1.

## Test plan
- Single packet: 5 words 0x01..0x05, rx_byte_num=20 → tx_start_en 2 cycles after rx_pkg_done, tx_byte_num=20, tx_data 0x01..0x05 on successive tx_req, pkt_cnt 1→0.
- Queue: 3 packets of 4/7/1 words back-to-back → replayed in order with matching byte counts. Spacing ≥ IFG_CYCLES+2 after each tx_pkg_done.
- Overflow, DEPTH=16: queue a 10-word packet, then send a 10-word packet without draining → second packet dropped, drop_cnt=1, first replays intact. A following 6-word packet commits.
- Descriptor full, MAX_PKTS=2, TX stalled (no tx_pkg_done) → third packet dropped, drop_cnt=1, pkt_cnt=2.
- Simultaneous rx_en+rx_pkg_done on the last word, with a commit in the same cycle as a pop → word included, pkt_cnt correct. With loop_en=0 the packet is discarded and drop_cnt is unchanged.
- Assert rst_n=0 during SEND → all outputs at reset values next cycle. No replay of old data.
